// File: rtl/usb_arb_pkg.sv
// Shared types and constants for the usbSlave register-port arbiter.
package usb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // 0 = host CPU bus, 1 = endpoint-service engine
    typedef logic req_idx_t;

    localparam logic [7:0] ABORT_DATA = 8'hFF;

endpackage

// File: rtl/usb_arb_rr_pick.sv
// Combinational two-way round-robin pick: on a tie the requester not granted last wins.
module usb_arb_rr_pick
    import usb_arb_pkg::*;
(
    input  logic     strobe0,
    input  logic     strobe1,
    input  req_idx_t last_grant,
    output logic     valid,
    output req_idx_t winner
);

    always_comb begin
        valid  = strobe0 | strobe1;
        winner = 1'b0;
        if (strobe0 && strobe1) begin
            winner = ~last_grant;
        end else if (strobe1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/usb_slave_bus_arbiter.sv
// Serialises host-CPU and endpoint-engine accesses onto the usbSlave register port.
// Define USB_ARB_TIMEOUT_EN to add a watchdog that aborts accesses the core never acks.
module usb_slave_bus_arbiter
    import usb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] m0_address_i,
    input  logic [7:0] m0_data_i,
    input  logic       m0_we_i,
    input  logic       m0_strobe_i,
    output logic [7:0] m0_data_o,
    output logic       m0_ack_o,
    output logic       m0_err_o,
    input  logic [7:0] m1_address_i,
    input  logic [7:0] m1_data_i,
    input  logic       m1_we_i,
    input  logic       m1_strobe_i,
    output logic [7:0] m1_data_o,
    output logic       m1_ack_o,
    output logic       m1_err_o,
    output logic [7:0] s_address_o,
    output logic [7:0] s_data_o,
    output logic       s_we_o,
    output logic       s_strobe_o,
    input  logic [7:0] s_data_i,
    input  logic       s_ack_i,
    output arb_state_e state_o
);

    // Handshake: a requester raises strobe with address/data/we stable and holds it
    // until it sees its one-cycle ack; it drops strobe on the following edge.
    arb_state_e state, state_next;
    req_idx_t   grant, last_grant, pick;
    logic       pick_valid;
    logic       grant_req, complete, abort;
    logic       wd_expired;

    usb_arb_rr_pick u_pick (
        .strobe0    (m0_strobe_i),
        .strobe1    (m1_strobe_i),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick)
    );

`ifdef USB_ARB_TIMEOUT_EN
    // wd_cnt counts completed BUSY cycles; the last allowed one triggers the abort
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wd_cnt <= '0;
        end else if (state != BUSY) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    assign wd_expired = (state == BUSY) && (wd_cnt == TIMEOUT_LAST);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = BUSY;
            BUSY:    if (s_ack_i || wd_expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An ack arriving in the same cycle as the watchdog expiry takes precedence
    always_comb begin
        grant_req = (state == IDLE) && pick_valid;
        complete  = (state == BUSY) && s_ack_i;
        abort     = (state == BUSY) && !s_ack_i && wd_expired;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s_address_o <= '0;
            s_data_o    <= '0;
            s_we_o      <= 1'b0;
            s_strobe_o  <= 1'b0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            m0_data_o   <= '0;
            m1_data_o   <= '0;
            m0_ack_o    <= 1'b0;
            m1_ack_o    <= 1'b0;
            m0_err_o    <= 1'b0;
            m1_err_o    <= 1'b0;
        end else begin
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;
            if (grant_req) begin
                s_address_o <= pick ? m1_address_i : m0_address_i;
                s_data_o    <= pick ? m1_data_i    : m0_data_i;
                s_we_o      <= pick ? m1_we_i      : m0_we_i;
                s_strobe_o  <= 1'b1;
                grant       <= pick;
            end
            if (complete || abort) begin
                s_strobe_o <= 1'b0;
                last_grant <= grant;
                if (grant) begin
                    m1_ack_o  <= 1'b1;
                    m1_err_o  <= abort;
                    m1_data_o <= abort ? ABORT_DATA : s_data_i;
                end else begin
                    m0_ack_o  <= 1'b1;
                    m0_err_o  <= abort;
                    m0_data_o <= abort ? ABORT_DATA : s_data_i;
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_usb_slave_bus_arbiter.sv
// Directed self-checking bench for usb_slave_bus_arbiter (watchdog checks when USB_ARB_TIMEOUT_EN).
module tb_usb_slave_bus_arbiter;
    import usb_arb_pkg::*;

    logic       clk;
    logic       rstn;
    logic [7:0] m0_address, m0_wdata, m1_address, m1_wdata;
    logic       m0_we, m0_strobe, m1_we, m1_strobe;
    logic [7:0] m0_rdata, m1_rdata;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic [7:0] s_address, s_wdata, s_rdata;
    logic       s_we, s_strobe, s_ack;
    arb_state_e state;

    int tests_run;
    int tests_failed;

    usb_slave_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .m0_address_i (m0_address),
        .m0_data_i    (m0_wdata),
        .m0_we_i      (m0_we),
        .m0_strobe_i  (m0_strobe),
        .m0_data_o    (m0_rdata),
        .m0_ack_o     (m0_ack),
        .m0_err_o     (m0_err),
        .m1_address_i (m1_address),
        .m1_data_i    (m1_wdata),
        .m1_we_i      (m1_we),
        .m1_strobe_i  (m1_strobe),
        .m1_data_o    (m1_rdata),
        .m1_ack_o     (m1_ack),
        .m1_err_o     (m1_err),
        .s_address_o  (s_address),
        .s_data_o     (s_wdata),
        .s_we_o       (s_we),
        .s_strobe_o   (s_strobe),
        .s_data_i     (s_rdata),
        .s_ack_i      (s_ack),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL time_limit: got no finish, expected finish before limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Called on the first BUSY cycle; core acks at the lat-th rising edge
    task automatic core_ack(input int lat, input logic [7:0] rdata);
        for (int i = 1; i < lat; i++) tick();
        s_ack   = 1'b1;
        s_rdata = rdata;
        tick();
        s_ack   = 1'b0;
        s_rdata = 8'h00;
    endtask

    task automatic expect_done(input string tag, input logic who, input logic [7:0] data,
                               input logic err);
        check({tag, "_state"},    32'(state),    32'(DONE));
        check({tag, "_s_strobe"}, 32'(s_strobe), 32'd0);
        if (who) begin
            check({tag, "_m1_ack"},  32'(m1_ack),   32'd1);
            check({tag, "_m0_ack"},  32'(m0_ack),   32'd0);
            check({tag, "_m1_data"}, 32'(m1_rdata), 32'(data));
            check({tag, "_m1_err"},  32'(m1_err),   32'(err));
        end else begin
            check({tag, "_m0_ack"},  32'(m0_ack),   32'd1);
            check({tag, "_m1_ack"},  32'(m1_ack),   32'd0);
            check({tag, "_m0_data"}, 32'(m0_rdata), 32'(data));
            check({tag, "_m0_err"},  32'(m0_err),   32'(err));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rstn       = 1'b0;
        m0_address = 8'h00; m0_wdata = 8'h00; m0_we = 1'b0; m0_strobe = 1'b0;
        m1_address = 8'h00; m1_wdata = 8'h00; m1_we = 1'b0; m1_strobe = 1'b0;
        s_rdata    = 8'h00; s_ack = 1'b0;
        tick();
        tick();

        check("rst_state",    32'(state),     32'(IDLE));
        check("rst_s_strobe", 32'(s_strobe),  32'd0);
        check("rst_s_addr",   32'(s_address), 32'd0);
        check("rst_s_data",   32'(s_wdata),   32'd0);
        check("rst_s_we",     32'(s_we),      32'd0);
        check("rst_acks",     32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        check("rst_m0_data",  32'(m0_rdata),  32'd0);
        check("rst_m1_data",  32'(m1_rdata),  32'd0);
        rstn = 1'b1;
        tick();

        // m0 read, core acks after two cycles
        m0_address = 8'h10; m0_we = 1'b0; m0_strobe = 1'b1;
        tick();
        check("rd_s_strobe", 32'(s_strobe),  32'd1);
        check("rd_s_addr",   32'(s_address), 32'h10);
        check("rd_s_we",     32'(s_we),      32'd0);
        check("rd_state",    32'(state),     32'(BUSY));
        check("rd_no_ack",   32'(m0_ack),    32'd0);
        core_ack(2, 8'h5A);
        expect_done("rd", 1'b0, 8'h5A, 1'b0);
        m0_strobe = 1'b0;
        tick();
        check("rd_ack_one", 32'(m0_ack), 32'd0);
        check("rd_idle",    32'(state),  32'(IDLE));

        // stray core ack while idle
        s_ack = 1'b1; s_rdata = 8'hEE;
        tick();
        s_ack = 1'b0; s_rdata = 8'h00;
        check("idle_ack_state", 32'(state),           32'(IDLE));
        check("idle_ack_pulse", 32'({m0_ack, m1_ack}), 32'd0);
        check("idle_ack_data",  32'(m0_rdata),        32'h5A);

        // ties after reset: m0, then m1 on the repeat tie, then m0
        do_reset();
        m0_address = 8'h21; m1_address = 8'h31;
        m0_strobe  = 1'b1;  m1_strobe  = 1'b1;
        tick();
        check("tie1_addr", 32'(s_address), 32'h21);
        core_ack(1, 8'hA1);
        expect_done("tie1", 1'b0, 8'hA1, 1'b0);
        m0_strobe = 1'b0;
        tick();
        check("tie1_idle", 32'(state), 32'(IDLE));
        m0_address = 8'h22; m0_strobe = 1'b1;
        tick();
        check("tie2_addr", 32'(s_address), 32'h31);
        core_ack(1, 8'hB1);
        expect_done("tie2", 1'b1, 8'hB1, 1'b0);
        m1_strobe = 1'b0;
        tick();
        tick();
        check("tie3_addr", 32'(s_address), 32'h22);
        core_ack(1, 8'hA2);
        expect_done("tie3", 1'b0, 8'hA2, 1'b0);
        m0_strobe = 1'b0;
        tick();

        // m1 write
        m1_address = 8'h03; m1_wdata = 8'hC4; m1_we = 1'b1; m1_strobe = 1'b1;
        tick();
        check("wr_s_addr",   32'(s_address), 32'h03);
        check("wr_s_data",   32'(s_wdata),   32'hC4);
        check("wr_s_we",     32'(s_we),      32'd1);
        check("wr_s_strobe", 32'(s_strobe),  32'd1);
        core_ack(3, 8'h00);
        check("wr_m1_ack", 32'(m1_ack), 32'd1);
        check("wr_m0_ack", 32'(m0_ack), 32'd0);
        check("wr_m1_err", 32'(m1_err), 32'd0);
        m1_strobe = 1'b0; m1_we = 1'b0;
        tick();

        // requester abandons strobe mid-access; access still completes
        m0_address = 8'h40; m0_strobe = 1'b1;
        tick();
        m0_strobe = 1'b0;
        core_ack(2, 8'h3C);
        expect_done("drop", 1'b0, 8'h3C, 1'b0);
        tick();

        m0_address = 8'h50; m0_strobe = 1'b1;
        tick();
`ifdef USB_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        check("wd_busy7", 32'(state),  32'(BUSY));
        check("wd_noack", 32'(m0_ack), 32'd0);
        tick();
        expect_done("wd_abort", 1'b0, ABORT_DATA, 1'b1);
        m0_strobe = 1'b0;
        tick();
        m0_strobe = 1'b1;
        tick();
        core_ack(8, 8'h99);
        expect_done("wd_ack8", 1'b0, 8'h99, 1'b0);
`else
        for (int i = 0; i < 20; i++) tick();
        check("nowd_busy",   32'(state),    32'(BUSY));
        check("nowd_strobe", 32'(s_strobe), 32'd1);
        check("nowd_noack",  32'(m0_ack),   32'd0);
        core_ack(1, 8'h99);
        expect_done("nowd", 1'b0, 8'h99, 1'b0);
`endif
        m0_strobe = 1'b0;
        tick();

        // reset mid-access: asynchronous clear, no ack, m0 wins the next tie
        m0_address = 8'h60; m0_strobe = 1'b1;
        tick();
        tick();
        check("rstb_busy", 32'(state), 32'(BUSY));
        #1 rstn = 1'b0;
        #1;
        check("rstb_s_strobe", 32'(s_strobe),  32'd0);
        check("rstb_s_addr",   32'(s_address), 32'd0);
        check("rstb_state",    32'(state),     32'(IDLE));
        check("rstb_m0_data",  32'(m0_rdata),  32'd0);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        check("rstb_noack", 32'({m0_ack, m1_ack}), 32'd0);
        rstn = 1'b1;
        m1_address = 8'h61; m1_strobe = 1'b1;
        tick();
        check("rstb_tie_addr", 32'(s_address), 32'h60);
        core_ack(1, 8'h6A);
        expect_done("rstb_m0", 1'b0, 8'h6A, 1'b0);
        m0_strobe = 1'b0;
        tick();
        tick();
        check("rstb_m1_addr", 32'(s_address), 32'h61);
        core_ack(1, 8'h6B);
        expect_done("rstb_m1", 1'b1, 8'h6B, 1'b0);
        m1_strobe = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
